// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD timer: FSM states, BCD digit type,
// and a digit-legality helper.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic logic digit_ok(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: sync clear wins over increment, wraps 9 -> 0, carry flags 9.
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       inc,
  output bcd_digit_t digit,
  output logic       carry
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Cascaded BCD timer with IDLE/RUN/DONE control and a valid/ready event.
// Optional tick prescaler enabled by defining BCD_TIMER_CTRL_PRESCALE_EN.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  periodic,
  input  logic [4*NDIG-1:0]     tc_bcd,
`ifdef BCD_TIMER_CTRL_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [4*NDIG-1:0]     cnt_bcd,
  output logic                  busy,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic                  overrun
);

  state_t              state_q, state_d;
  logic [4*NDIG-1:0]   tc_q, tc_d;
  logic                per_q, per_d;
  logic                evt_q, evt_d;
  logic                ovr_q, ovr_d;
  logic                cnt_clr, cnt_inc, tick, match, tc_ok;
  logic [NDIG-1:0]     carry, inc_en, dig_ok;

`ifdef BCD_TIMER_CTRL_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  assign tick = (state_q == RUN) && (psc_q == prescale);
`else
  assign tick = (state_q == RUN);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      assign dig_ok[gi] = digit_ok(tc_bcd[4*gi +: 4]);
      // A digit advances only when every lower digit sits at 9.
      if (gi == 0) begin : g_lsd
        assign inc_en[gi] = cnt_inc;
      end else begin : g_upper
        assign inc_en[gi] = cnt_inc & (&carry[gi-1:0]);
      end
      bcd_digit u_digit (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (cnt_clr),
        .inc   (inc_en[gi]),
        .digit (cnt_bcd[4*gi +: 4]),
        .carry (carry[gi])
      );
    end
  endgenerate

  assign tc_ok = (&dig_ok) && (|tc_bcd);
  assign match = (cnt_bcd == tc_q);

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    per_d   = per_q;
    evt_d   = evt_q & ~evt_ready;
    ovr_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`ifdef BCD_TIMER_CTRL_PRESCALE_EN
    psc_d   = ((state_q == RUN) && !tick) ? psc_q + 1'b1 : '0;
`endif
    if (clear) begin
      state_d = IDLE;
      evt_d   = 1'b0;
      cnt_clr = 1'b1;
`ifdef BCD_TIMER_CTRL_PRESCALE_EN
      psc_d   = '0;
`endif
    end else if (stop && (state_q == RUN)) begin
      state_d = IDLE;
`ifdef BCD_TIMER_CTRL_PRESCALE_EN
      psc_d   = '0;
`endif
    end else if (start && !stop && (state_q == IDLE) && tc_ok) begin
      tc_d    = tc_bcd;
      per_d   = periodic;
      cnt_clr = 1'b1;
      state_d = RUN;
`ifdef BCD_TIMER_CTRL_PRESCALE_EN
      psc_d   = '0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            if (match) begin
              // A match with an unacknowledged event is reported, not queued.
              cnt_clr = 1'b1;
              evt_d   = 1'b1;
              ovr_d   = evt_q & ~evt_ready;
              if (!per_q) state_d = DONE;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        DONE: begin
          if (evt_q && evt_ready) state_d = IDLE;
        end
        IDLE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      tc_q    <= '0;
      per_q   <= 1'b0;
      evt_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      per_q   <= per_d;
      evt_q   <= evt_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef BCD_TIMER_CTRL_PRESCALE_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) psc_q <= '0;
    else       psc_q <= psc_d;
  end
`endif

  assign busy      = (state_q != IDLE);
  assign evt_valid = evt_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl: directed scenarios plus random
// control traffic checked every cycle against an integer-arithmetic model.
module tb_bcd_timer_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, stop, clear, periodic, evt_ready;
  logic [15:0] tc_bcd;
  logic [15:0] cnt_bcd;
  logic        busy, evt_valid, overrun;
`ifdef BCD_TIMER_CTRL_PRESCALE_EN
  logic [7:0]  prescale;
`endif

  always #5 clk = ~clk;

  bcd_timer_ctrl #(.NDIG(4), .PRESCALE_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .periodic  (periodic),
    .tc_bcd    (tc_bcd),
`ifdef BCD_TIMER_CTRL_PRESCALE_EN
    .prescale  (prescale),
`endif
    .cnt_bcd   (cnt_bcd),
    .busy      (busy),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .overrun   (overrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: decimal integers, 0 = idle, 1 = running, 2 = done
  int m_st, m_cnt, m_tc, m_psc;
  bit m_per, m_evt, m_ovr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] b);
    int v = 0;
    for (int k = 3; k >= 0; k--) v = v * 10 + int'(b[4*k +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit tc_legal(input logic [15:0] b);
    bit ok = (b != 16'h0);
    for (int k = 0; k < 4; k++) if (b[4*k +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_tc = 0; m_psc = 0;
    m_per = 0; m_evt = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    bit hs, was_evt, tick;
    int pdiv;
    pdiv = 0;
`ifdef BCD_TIMER_CTRL_PRESCALE_EN
    pdiv = int'(prescale);
`endif
    hs      = m_evt && evt_ready;
    was_evt = m_evt;
    m_ovr   = 0;
    if (clear) begin
      m_st = 0; m_cnt = 0; m_evt = 0; m_psc = 0;
    end else if (stop && m_st == 1) begin
      m_st = 0; m_psc = 0; m_evt = m_evt && !hs;
    end else if (start && !stop && m_st == 0 && tc_legal(tc_bcd)) begin
      m_tc = bcd2int(tc_bcd); m_per = periodic; m_cnt = 0; m_st = 1; m_psc = 0;
      m_evt = m_evt && !hs;
    end else begin
      m_evt = m_evt && !hs;
      if (m_st == 1) begin
        tick  = (m_psc == pdiv);
        m_psc = tick ? 0 : m_psc + 1;
        if (tick) begin
          if (m_cnt == m_tc) begin
            m_cnt = 0;
            m_ovr = was_evt && !hs;
            m_evt = 1;
            if (!m_per) m_st = 2;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end else if (m_st == 2 && hs) begin
        m_st = 0;
      end
    end
  endtask

  task automatic compare_all(input string pfx);
    check_val({pfx, "_cnt"},  cnt_bcd,   int2bcd(m_cnt));
    check_val({pfx, "_busy"}, busy,      m_st != 0);
    check_val({pfx, "_evt"},  evt_valid, m_evt);
    check_val({pfx, "_ovr"},  overrun,   m_ovr);
  endtask

  // Inputs are already set; advance one clock and compare against the model.
  task automatic cycle(input string pfx);
    if (m_evt && evt_ready) $display("event accepted t=%0t cnt=%h", $time, cnt_bcd);
    model_step();
    @(posedge clk);
    #1;
    compare_all(pfx);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    model_reset();
    check_val("rst_cnt",  cnt_bcd,   16'h0);
    check_val("rst_busy", busy,      1'b0);
    check_val("rst_evt",  evt_valid, 1'b0);
    check_val("rst_ovr",  overrun,   1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; clear = 0;
  endtask

  int pulses;

  initial begin
    rstn = 1'b0; start = 0; stop = 0; clear = 0; periodic = 0;
    evt_ready = 0; tc_bcd = '0;
`ifdef BCD_TIMER_CTRL_PRESCALE_EN
    prescale = 8'd0;
`endif
    @(posedge clk); #1;
    do_reset();

    // One-shot tc=5: counts 1..5, event on the sixth tick, then handshake to idle
    tc_bcd = 16'h0005; periodic = 0; start = 1;
    cycle("os_start");
    start = 0;
    check_val("os_busy0", busy, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      cycle("os_run");
      check_val("os_cnt", cnt_bcd, int2bcd(k));
    end
    cycle("os_match");
    check_val("os_evt", evt_valid, 1'b1);
    check_val("os_cnt0", cnt_bcd, 16'h0000);
    cycle("os_done");
    check_val("os_done_busy", busy, 1'b1);
    evt_ready = 1;
    cycle("os_ack");
    check_val("os_idle_busy", busy, 1'b0);
    check_val("os_idle_evt", evt_valid, 1'b0);
    evt_ready = 0;

    // Periodic tc=3 with no consumer: second match raises a one-cycle overrun
    tc_bcd = 16'h0003; periodic = 1; start = 1;
    cycle("ov_start");
    start = 0;
    for (int k = 0; k < 4; k++) cycle("ov_run1");
    check_val("ov_evt1", evt_valid, 1'b1);
    check_val("ov_none", overrun, 1'b0);
    for (int k = 0; k < 4; k++) cycle("ov_run2");
    check_val("ov_pulse", overrun, 1'b1);
    check_val("ov_evt2", evt_valid, 1'b1);
    cycle("ov_after");
    check_val("ov_gone", overrun, 1'b0);
    clear = 1;
    cycle("ov_clear");
    clear = 0;
    check_val("ov_clr_evt", evt_valid, 1'b0);

    // Illegal terminal counts are refused
    tc_bcd = 16'h00A2; start = 1;
    cycle("bad_a2");
    check_val("bad_a2_busy", busy, 1'b0);
    tc_bcd = 16'h0000;
    cycle("bad_zero");
    check_val("bad_zero_busy", busy, 1'b0);
    start = 0;

    // Stop beats start; count holds; clear zeroes; reset mid-run
    tc_bcd = 16'h0099; periodic = 1; start = 1;
    cycle("ss_start");
    start = 0;
    for (int k = 0; k < 4; k++) cycle("ss_run");
    check_val("ss_cnt4", cnt_bcd, 16'h0004);
    stop = 1; start = 1;
    cycle("ss_stop");
    idle_inputs();
    cycle("ss_hold");
    check_val("ss_hold_cnt", cnt_bcd, 16'h0004);
    check_val("ss_hold_busy", busy, 1'b0);
    clear = 1;
    cycle("ss_clear");
    clear = 0;
    check_val("ss_clr_cnt", cnt_bcd, 16'h0000);
    start = 1;
    cycle("ss_restart");
    start = 0;
    for (int k = 0; k < 7; k++) cycle("ss_run2");
    do_reset();

    // Periodic tc=99 with consumer always ready: one event per 100 cycles
    tc_bcd = 16'h0099; periodic = 1; evt_ready = 1; start = 1;
    cycle("p99_start");
    start = 0;
    pulses = 0;
    for (int k = 1; k <= 200; k++) begin
      cycle("p99_run");
      if (k == 10) check_val("p99_carry", cnt_bcd, 16'h0010);
      if (evt_valid) pulses++;
    end
    check_val("p99_pulses", pulses, 2);
    stop = 1;
    cycle("p99_stop");
    stop = 0; evt_ready = 0;

`ifdef BCD_TIMER_CTRL_PRESCALE_EN
    // Prescale 3, tc=2: event twelve cycles after start
    clear = 1; cycle("ps_clear"); clear = 0;
    prescale = 8'd3; tc_bcd = 16'h0002; periodic = 0; start = 1;
    cycle("ps_start");
    start = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle("ps_run");
      if (k == 4)  check_val("ps_cnt1", cnt_bcd, 16'h0001);
      if (k == 11) check_val("ps_evt_early", evt_valid, 1'b0);
    end
    check_val("ps_evt", evt_valid, 1'b1);
`endif

    // Random control traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      clear     = ($urandom_range(0, 63) == 0);
      stop      = ($urandom_range(0, 31) == 0);
      start     = ($urandom_range(0, 7) == 0);
      periodic  = $urandom_range(0, 1);
      evt_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       tc_bcd = 16'($urandom);
        1:       tc_bcd = 16'h0000;
        2:       tc_bcd = int2bcd($urandom_range(1, 9999));
        default: tc_bcd = int2bcd($urandom_range(1, 25));
      endcase
`ifdef BCD_TIMER_CTRL_PRESCALE_EN
      prescale = 8'($urandom_range(0, 3));
`endif
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter NDIG, default 4: number of cascaded BCD decade digits.
REQ-002 Parameter PRESCALE_W, default 8: prescaler width (used only with BCD_TIMER_CTRL_PRESCALE_EN).
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin a count run.
REQ-006 stop  input  1  abort run, freeze count.
REQ-007 clear  input  1  synchronous clear of count, FSM and event.
REQ-008 periodic  input  1  1 = auto-restart after match; 0 = one-shot; sampled with start.
REQ-009 tc_bcd  input  4*NDIG  terminal count, BCD, digit 0 in bits [3:0]; sampled with start.
REQ-010 prescale  input  PRESCALE_W  tick divider; port exists only with BCD_TIMER_CTRL_PRESCALE_EN.
REQ-011 cnt_bcd  output  4*NDIG  current BCD count.
REQ-012 busy  output  1  high when FSM is not IDLE.
REQ-013 evt_valid  output  1  terminal-count event pending.
REQ-014 evt_ready  input  1  consumer accepts event.
REQ-015 overrun  output  1  one-cycle pulse: match occurred while event still pending.

Function
REQ-016 FSM states IDLE, RUN, DONE; busy = (state != IDLE).
REQ-017 Control priority, per cycle: clear > stop > start.
REQ-018 IDLE + start: tc_bcd and periodic latched, cnt_bcd -> 0, state -> RUN at same edge.
REQ-019 start SHALL be ignored (stay IDLE, no latch) if tc_bcd == 0 or any tc digit > 9.
REQ-020 RUN, on each tick: digit 0 increments; digit k increments only when digits 0..k-1 all == 9; a digit at 9 wraps to 0.
REQ-021 RUN, tick with cnt_bcd == latched tc: cnt_bcd -> 0 and evt_valid -> 1 at that edge; period = tc+1 ticks.
REQ-022 Latency (no prescaler): start sampled at edge E0, tc=5 -> cnt 1..5 at E1..E5, evt_valid=1 and cnt=0 after E6.
REQ-023 Match with periodic=1: stay RUN, counting continues from 0; periodic=0: state -> DONE, counting halts.
REQ-024 evt_valid held until sampled evt_valid && evt_ready; then cleared next edge.
REQ-025 Match while evt_valid already 1: overrun = 1 for one cycle, evt_valid stays 1, no extra event queued.
REQ-026 Match and evt_ready handshake in same cycle: evt_valid remains 1 (new event), overrun = 0.
REQ-027 DONE -> IDLE on the edge completing the event handshake; start in DONE ignored.
REQ-028 stop in RUN: state -> IDLE, cnt_bcd held, pending evt_valid unaffected.
REQ-029 clear: cnt_bcd -> 0, state -> IDLE, evt_valid -> 0, overrun -> 0, prescaler -> 0.
REQ-030 start while RUN ignored (no retrigger).

Reset
REQ-031 rstn low: state IDLE, cnt_bcd 0, latched tc 0, periodic 0, evt_valid 0, overrun 0, busy 0, prescaler 0.
REQ-032 Reset mid-run SHALL discard run and pending event with no overrun pulse.

Configuration
REQ-033 Macro BCD_TIMER_CTRL_PRESCALE_EN defined: prescale port present; in RUN tick asserts once every prescale+1 clk cycles; prescaler restarts at 0 on start, stop, clear.
REQ-034 Macro undefined: no prescale port, no prescaler register; tick = 1 every cycle in RUN.

Structure
REQ-035 Package bcd_timer_pkg: FSM state enum, 4-bit BCD digit typedef, constant BCD_MAX = 9.
REQ-036 Sub-module bcd_digit: one decade digit with inc-enable, sync clear, carry (digit == 9); instantiated NDIG times.

Verification
REQ-037 tc=0005, periodic=0, no prescale: start -> cnt 1..5 cycles 1..5, evt_valid cycle 6, DONE; evt_ready=1 -> IDLE, busy 0.
REQ-038 tc=0099, periodic=1, evt_ready held 1: evt_valid pulses every 100 cycles; cnt 0099 -> 0000 on match, 0009 -> 0010 carry.
REQ-039 tc=0003, periodic=1, evt_ready=0: first match sets evt_valid; second match (4 cycles later) pulses overrun, evt_valid stays 1.
REQ-040 tc=00A2 or tc=0000 with start -> busy stays 0, cnt unchanged.
REQ-041 RUN at cnt=0004 with stop and start same cycle -> IDLE, cnt holds 0004; then clear -> cnt 0000; rstn pulse mid-run -> all outputs 0.
REQ-042 With BCD_TIMER_CTRL_PRESCALE_EN, prescale=3, tc=0002: cnt increments every 4 cycles, evt_valid 12 cycles after start.
